mor1kx_icache_refill_wb: RTL
============================

// Module: mor1kx_icache_refill_wb
// PURPOSE
//  Refill engine between the instruction cache and the Wishbone instruction bus.
//  - Starts when the cache enters REFILL; fetches one cache line, critical word first, in wrap order.
//  - Feeds the cache write port (wradr/wrdat/we) one word per bus ack.
//  - Reports bus errors to the cache as imem_err.
// PARAMETERS
//  OPTION_OPERAND_WIDTH       32  data/address width; only 32 supported
//  OPTION_ICACHE_BLOCK_WIDTH  5   log2 line bytes; 4 (4 words, wrap4) or 5 (8 words, wrap8)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  refill_i        in   1   cache is in REFILL state
//  refill_adr_i    in   32  miss address; sampled on rising edge of refill_i
//  wradr_o         out  32  cache write address (word aligned)
//  wrdat_o         out  32  cache write data
//  we_o            out  1   cache write strobe, 1-cycle pulse per word
//  imem_err_o      out  1   bus error pulse to cache (ic_imem_err)
//  wbm_adr_o       out  32  bus address
//  wbm_cyc_o       out  1   bus cycle
//  wbm_stb_o       out  1   bus strobe
//  wbm_we_o        out  1   tied 0
//  wbm_sel_o       out  4   tied 4'hf
//  wbm_cti_o       out  3   cycle type
//  wbm_bte_o       out  2   burst type
//  wbm_dat_i       in   32  read data
//  wbm_ack_i       in   1   ack
//  wbm_err_i       in   1   error
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE; bus released in the same cycle rst asserts (async).
//  - FSM states:
//    - IDLE: on refill_i & !refill_q, latch adr = {refill_adr_i[31:2],2'b00}; count = 0; assert cyc/stb; go BURST.
//    - BURST: on ack:
//      - wradr_o <= wbm_adr_o; wrdat_o <= wbm_dat_i; we_o <= 1 (registered, 1-cycle latency).
//      - Advance adr: increment word index within the line, modulo the line (upper bits fixed); count++.
//      - On the ack of the last word (count == WORDS-1): drop cyc/stb next cycle; go DONE.
//    - On err (err has priority over ack): drop cyc/stb next cycle; imem_err_o <= 1 for one cycle; no we_o for that beat; go DONE.
//    - DONE: wait for !refill_i, then go IDLE. This prevents a second burst while the cache still shows REFILL.
//  - refill_i falling while in BURST (cache aborted): drop cyc/stb at the end of the current beat; go IDLE; do not assert we_o afterwards.
//  - cyc and stb are identical; the address is held stable while stb is high and ack is low (stall of any length is legal).
//  - wbm_bte_o = 2'b01 for a 16-byte line, 2'b10 for a 32-byte line.
//  - Simultaneous rst and ack: rst wins; no we_o.
// CONFIGURATION
//  Macro MOR1KX_ICACHE_REFILL_BURST_EN:
//  - Defined: one continuous registered-feedback burst.
//    - cti = 3'b010 on every beat except the last, which uses 3'b111.
//    - Next stb is issued in the cycle after each ack, with the new address.
//  - Undefined: classic cycles, cti = 3'b000 and bte = 2'b00.
//    - stb deasserts for one cycle after each ack, then reasserts with the next wrap address.
//    - Word order and cache-side behaviour are identical to the burst build.
// STRUCTURE
//  - Shared package / mor1kx-defines.v: CTI_CLASSIC / CTI_INC / CTI_EOB and BTE_WRAP4 / BTE_WRAP8 constants, plus the state encoding.
//  - One natural sub-module, mor1kx_refill_wrap_adr (combinational wrap incrementer, BLOCK_WIDTH parameter).
//  - FSM and datapath stay in this module.
// TESTING
//  - BLOCK_WIDTH 5, start 0x1014, ack every cycle: we_o at 0x1014,18,1C,00,04,08,0C,10; 8 pulses; cti 010x7 then 111; bte 10; cyc low after the 8th ack.
//  - BLOCK_WIDTH 4, start 0x200C, ack every 3rd cycle: adr 0x200C,00,04,08; adr stable during stalls; bte 01.
//  - err on 3rd beat: exactly 2 we_o pulses; imem_err_o one cycle; cyc low next cycle; no new burst until refill_i drops.
//  - rst asserted mid-burst after 4 acks: cyc/stb/we_o go 0 immediately; after release, a refill_i edge at 0x3000 starts a clean burst from 0x3000.
//  - refill_i held high after the last word: no second burst; refill_i low then high again at 0x4018: new burst from 0x4018.
//  - Macro undefined: same address/data order as the first scenario; cti 000; stb low for one cycle between beats.

Source files
------------

// File: rtl/mor1kx_icache_refill_wb_pkg.sv
// Shared constants for the instruction-cache refill engine: Wishbone cycle/burst
// type encodings and the refill FSM state encoding.
package mor1kx_icache_refill_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } refill_state_e;

    // 16-byte lines wrap at 4 words, 32-byte lines at 8 words.
    function automatic logic [1:0] bte_for_block(input int unsigned block_width);
        return (block_width == 4) ? BTE_WRAP4 : BTE_WRAP8;
    endfunction

endpackage

// File: rtl/mor1kx_refill_wrap_adr.sv
// Combinational wrap incrementer: advances the word index inside a cache line,
// wrapping modulo the line, while the line-select bits stay fixed.
module mor1kx_refill_wrap_adr #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH          = 5
) (
    input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] next_adr_o
);

    localparam int unsigned IdxW = BLOCK_WIDTH - 2;

    logic [IdxW-1:0] idx;

    assign idx        = adr_i[BLOCK_WIDTH-1:2] + IdxW'(1);
    assign next_adr_o = {adr_i[OPTION_OPERAND_WIDTH-1:BLOCK_WIDTH], idx, 2'b00};

endmodule

// File: rtl/mor1kx_icache_refill_wb.sv
// Instruction-cache line refill over Wishbone, critical word first in wrap order.
// Define MOR1KX_ICACHE_REFILL_BURST_EN for registered-feedback bursts; otherwise classic cycles.
module mor1kx_icache_refill_wb
    import mor1kx_icache_refill_wb_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH      = 32,
    parameter int unsigned OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i
);

    localparam int unsigned AW   = OPTION_OPERAND_WIDTH;
    localparam int unsigned CntW = OPTION_ICACHE_BLOCK_WIDTH - 2;

    refill_state_e   state_q, state_d;
    logic            refill_q;
    logic [AW-1:0]   adr_q, adr_d, next_adr;
    logic [CntW-1:0] count_q, count_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [AW-1:0]   wradr_q, wradr_d;
    logic [AW-1:0]   wrdat_q, wrdat_d;

    logic start, last, beat_ack, beat_err;
    logic unused_adr_bits;

    assign start           = refill_i & ~refill_q;
    assign last            = &count_q;
    assign beat_err        = cyc_q & wbm_err_i;
    assign beat_ack        = cyc_q & wbm_ack_i & ~wbm_err_i;
    assign unused_adr_bits = ^refill_adr_i[1:0];

    mor1kx_refill_wrap_adr #(
        .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH),
        .BLOCK_WIDTH          (OPTION_ICACHE_BLOCK_WIDTH)
    ) u_wrap_adr (
        .adr_i      (adr_q),
        .next_adr_o (next_adr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            refill_q <= 1'b0;
            adr_q    <= '0;
            count_q  <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wradr_q  <= '0;
            wrdat_q  <= '0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_i;
            adr_q    <= adr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wradr_q  <= wradr_d;
            wrdat_q  <= wrdat_d;
        end
    end

    // DONE holds until refill_i drops so a lingering REFILL cannot start a second burst.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StBurst;
            end
            StBurst: begin
                if (beat_err || beat_ack) begin
                    if (!refill_i)             state_d = StIdle;
                    else if (beat_err || last) state_d = StDone;
                end else if (!cyc_q && !refill_i) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (!refill_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        adr_d   = adr_q;
        count_d = count_q;
        cyc_d   = cyc_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        wradr_d = wradr_q;
        wrdat_d = wrdat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    adr_d   = {refill_adr_i[AW-1:2], 2'b00};
                    count_d = '0;
                    cyc_d   = 1'b1;
                end
            end
            StBurst: begin
                if (beat_err) begin
                    cyc_d = 1'b0;
                    err_d = refill_i;
                end else if (beat_ack) begin
                    cyc_d = 1'b0;
                    // An aborted refill completes the bus beat but never writes the cache.
                    if (refill_i) begin
                        we_d    = 1'b1;
                        wradr_d = adr_q;
                        wrdat_d = wbm_dat_i;
                        adr_d   = next_adr;
                        count_d = count_q + CntW'(1);
`ifdef MOR1KX_ICACHE_REFILL_BURST_EN
                        cyc_d   = ~last;
`else
                        cyc_d   = 1'b0;
`endif
                    end
                end else if (!cyc_q) begin
                    cyc_d = refill_i;
                end
            end
            default: cyc_d = 1'b0;
        endcase
    end

`ifdef MOR1KX_ICACHE_REFILL_BURST_EN
    localparam logic [1:0] BteLine = bte_for_block(OPTION_ICACHE_BLOCK_WIDTH);

    assign wbm_cti_o = !cyc_q ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INC);
    assign wbm_bte_o = cyc_q ? BteLine : BTE_LINEAR;
`else
    assign wbm_cti_o = CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;
`endif

    assign wbm_adr_o  = adr_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'hf;
    assign wradr_o    = wradr_q;
    assign wrdat_o    = wrdat_q;
    assign we_o       = we_q;
    assign imem_err_o = err_q;

endmodule
